// File: rtl/adc_serial_model.sv
// Bus-functional model of an SPI multi-channel ADC (ADC128S022 family).
// Oversamples CS_N/SCLK/SADDR on the board clock and drives SDAT back.
module adc_serial_model #(
  parameter int NUM_CH      = 8,
  parameter int DATA_BITS   = 12,
  parameter int FRAME_BITS  = 16,
  parameter int ADDR_BITS   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          ADC_CS_N,
  input  logic                          ADC_SCLK,
  input  logic                          ADC_SADDR,
  output logic                          ADC_SDAT,
  input  logic [NUM_CH*DATA_BITS-1:0]   ch_value,
  input  logic [1:0]                    pattern_mode,
  output logic [15:0]                   frame_count,
  output logic                          frame_error,
  output logic                          addr_error
);

  localparam int LZ    = FRAME_BITS - DATA_BITS;
  localparam int CNT_W = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, FRAME_END} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, saddr_sync;
  logic                   cs_prev, sclk_prev;
  logic                   cs_s, sclk_s, saddr_s;
  logic                   cs_rise, sclk_fall, sclk_rise, cs_fall;
  logic                   frame_load, bit_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   sclk_seen;
  logic [ADDR_BITS-1:0]   cur_ch, next_ch, load_ch, next_shift;
  logic [DATA_BITS-1:0]   ramp, load_value;
  logic [FRAME_BITS-1:0]  load_word, shreg;

  function automatic logic ch_invalid(input logic [ADDR_BITS-1:0] ch);
    return 32'(ch) >= 32'(NUM_CH);
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cs_sync    <= '1;
      sclk_sync  <= '1;
      saddr_sync <= '0;
      cs_prev    <= 1'b1;
      sclk_prev  <= 1'b1;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
      saddr_sync <= {saddr_sync[SYNC_STAGES-2:0], ADC_SADDR};
      cs_prev    <= cs_s;
      sclk_prev  <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign saddr_s   = saddr_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_fall = sclk_prev & ~sclk_s;
  assign sclk_rise = ~sclk_prev & sclk_s;

  // A CS_N rise always beats an SCLK edge seen in the same clock.
  assign frame_load = ((state == IDLE) && cs_fall) ||
                      ((state == FRAME_END) && !cs_rise && sclk_fall);
  assign bit_shift  = (state == SHIFT) && !cs_rise && sclk_fall;

  // The first frame after CS_N falls always converts IN0.
  assign load_ch    = (state == FRAME_END) ? cur_ch : '0;
  assign load_word  = {{LZ{1'b0}}, load_value};
  assign next_shift = (next_ch << 1) | ADDR_BITS'(saddr_s);

  always_comb begin
    load_value = '0;
    if (!ch_invalid(load_ch)) begin
      case (pattern_mode)
        2'd0: begin
          for (int n = 0; n < NUM_CH; n++)
            if (load_ch == ADDR_BITS'(n)) load_value = ch_value[n*DATA_BITS +: DATA_BITS];
        end
        2'd1:    load_value = (DATA_BITS'(load_ch) << (DATA_BITS - ADDR_BITS)) | DATA_BITS'(load_ch);
        2'd2:    load_value = ramp;
        default: load_value = '1;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (frame_load)     shreg <= load_word;
    else if (bit_shift) shreg <= shreg << 1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      ADC_SDAT    <= 1'b0;
      frame_count <= '0;
      frame_error <= 1'b0;
      addr_error  <= 1'b0;
      bit_cnt     <= '0;
      sclk_seen   <= 1'b0;
      cur_ch      <= '0;
      next_ch     <= '0;
      ramp        <= '0;
    end else begin
      frame_error <= 1'b0;
      addr_error  <= 1'b0;
      case (state)
        IDLE: begin
          ADC_SDAT <= 1'b0;
          if (frame_load) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            cur_ch    <= '0;
            sclk_seen <= 1'b0;
            ADC_SDAT  <= load_word[FRAME_BITS-1];
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state       <= IDLE;
            ADC_SDAT    <= 1'b0;
            frame_error <= sclk_seen || (bit_cnt != '0);
          end else if (bit_shift) begin
            sclk_seen <= 1'b1;
            bit_cnt   <= bit_cnt + 1'b1;
            ADC_SDAT  <= shreg[FRAME_BITS-2];
          end else if (sclk_rise) begin
            sclk_seen <= 1'b1;
            // Rising edge number within the frame is bit_cnt+1.
            if (bit_cnt >= CNT_W'(2) && bit_cnt <= CNT_W'(1 + ADDR_BITS)) begin
              next_ch <= next_shift;
              if (bit_cnt == CNT_W'(1 + ADDR_BITS)) addr_error <= ch_invalid(next_shift);
            end
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              frame_count <= frame_count + 16'd1;
              ramp        <= ramp + 1'b1;
              cur_ch      <= next_ch;
              state       <= FRAME_END;
            end
          end
        end
        FRAME_END: begin
          if (cs_rise) begin
            state    <= IDLE;
            ADC_SDAT <= 1'b0;
          end else if (frame_load) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            sclk_seen <= 1'b0;
            ADC_SDAT  <= load_word[FRAME_BITS-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
